message_scroller: RTL and testbench
===================================

Name: message_scroller

Overview:
- Upstream feeder for the per-digit ASCII-to-segment decoders.
- Holds a writable message buffer of ASCII bytes and presents a 6-character window, one byte per HEX digit.
- The window advances around the buffer at a prescaled scroll rate.
- Each window byte drives one decoder instance. Byte 0xFF is never produced unless it was written into the buffer.

Parameters:
- MSG_LEN, 16, buffer depth in characters; legal range 1..256.
- TICK_DIV, 25000000, clk cycles per scroll step (2 Hz at 50 MHz); legal range 2..2^32-1; benches use 4.
- ADDR_W, clog2(MSG_LEN) (min 1), width of buffer address/offset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  1 = auto-scroll on each prescaler tick.
- dir  in  1  0 = scroll left (offset+1), 1 = scroll right (offset-1).
- step  in  1  single-cycle pulse: advance one position in dir, honoured only when run=0.
- clear  in  1  synchronous: offset and prescaler to 0.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  ADDR_W  buffer write index.
- wr_data  in  8  ASCII byte to write.
- window  out  48  [47:40] = leftmost digit (HEX5) ... [7:0] = rightmost digit (HEX0).
- offset  out  ADDR_W  buffer index currently shown in the leftmost digit.
- tick  out  1  one-cycle pulse at each prescaler terminal count.

Behaviour:
- Reset (reset=0, async):
  - all buffer entries = 8'h20 (space); offset=0; prescaler=0; tick=0; window=48'h202020202020.
  - Deassertion is synchronised by the integrator; the block needs no internal sync.
- Prescaler:
  - counts 0..TICK_DIV-1, then wraps to 0.
  - tick is registered, =1 in the cycle after the count equals TICK_DIV-1; first tick appears TICK_DIV cycles after reset release.
  - Free-runs regardless of run.
- Advance event (adv), evaluated each cycle with priority clear > (run & tick_internal) > (~run & step):
  - clear: offset<=0, prescaler<=0, no advance that cycle.
  - dir=0: offset<=(offset==MSG_LEN-1)?0:offset+1.
  - dir=1: offset<=(offset==0)?MSG_LEN-1:offset-1.
  - step while run=1 is ignored; step is not queued.
- Buffer writes:
  - wr_en=1 and wr_addr<MSG_LEN: buf[wr_addr]<=wr_data at the clock edge.
  - wr_addr>=MSG_LEN: write dropped, no other effect.
  - A write and an advance in the same cycle both take effect.
- Window:
  - registered; window byte k (k=0 leftmost) = buf[(offset+k) mod MSG_LEN].
  - Computed from post-update offset and buffer, so changes appear exactly 1 cycle after the causing edge (offset output and window update in the same cycle).
  - MSG_LEN<6: the window repeats characters via the modulo, e.g. MSG_LEN=4 "ABCD" shows "ABCDAB".
  - MSG_LEN=1: offset stays 0; advances are no-ops on offset.
- Reset mid-scroll: the window immediately returns to all spaces; buffer contents are lost.
- Implementation: no combinational path from any input to any output.

Test Plan:
- Reset then load: TICK_DIV=4, MSG_LEN=8, run=0. Write "HELLO.CP" at addr 0..7. Next cycle window=48'h48454C4C4F2E, offset=0, tick pulses every 4th cycle.
- Auto-scroll left: run=1, dir=0. After each tick, offset goes 1,2,...,7,0. At offset=7, window="PHELLO" = 48'h5048454C4C4F.
- Scroll right with wrap: from offset=0, run=1, dir=1. One tick gives offset=7. The next gives offset=6, window="CPHELL".
- Step and priority: run=0, step pulse gives offset+1, window updated the cycle after. Assert step, run=1 and tick together: exactly one advance. Assert clear with tick: offset=0 and prescaler restarts, so the next tick comes 4 cycles later.
- Writes: writing 8'h49 ('I') to the address shown in HEX0 changes window[7:0] to 8'h49 the next cycle. A write with wr_addr=8 when MSG_LEN=8 (ADDR_W=4) leaves the buffer unchanged.
- Async reset mid-operation: pull reset low between clock edges during scrolling. window=48'h202020202020, offset=0 and tick=0 without a clock edge. After release, reads of all addresses return 8'h20.

Source files
------------

// File: rtl/message_scroller.sv
// Scrolling 6-character window over a writable ASCII message buffer.
// Feeds one byte per HEX digit to downstream ASCII-to-segment decoders.
module message_scroller #(
    parameter int unsigned MSG_LEN  = 16,
    parameter int unsigned TICK_DIV = 25000000,
    parameter int          ADDR_W   = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              dir,
    input  logic              step,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic [47:0]       window,
    output logic [ADDR_W-1:0] offset,
    output logic              tick
);

    localparam logic [31:0]       CNT_LAST = 32'(TICK_DIV - 32'd1);
    localparam logic [ADDR_W-1:0] OFF_LAST = ADDR_W'(MSG_LEN - 32'd1);
    localparam logic [ADDR_W-1:0] OFF_ZERO = {ADDR_W{1'b0}};

    logic [31:0]       cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [7:0]        msg_q [MSG_LEN];
    logic [7:0]        msg_d [MSG_LEN];
    logic [47:0]       window_q, window_d;
    logic              wr_ok_s;
    logic              adv_s;

    // Prescaler, advance arbitration and next offset
    always_comb begin
        cnt_d    = cnt_q;
        tick_d   = 1'b0;
        offset_d = offset_q;
        adv_s    = 1'b0;
        if (clear) begin
            cnt_d    = 32'd0;
            tick_d   = 1'b0;
            offset_d = OFF_ZERO;
        end else begin
            tick_d = (cnt_q == CNT_LAST);
            cnt_d  = tick_d ? 32'd0 : cnt_q + 32'd1;
            if (run) begin
                adv_s = tick_q;
            end else begin
                adv_s = step;
            end
            if (!adv_s) begin
                offset_d = offset_q;
            end else if (dir) begin
                offset_d = (offset_q == OFF_ZERO) ? OFF_LAST : offset_q - {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                offset_d = (offset_q == OFF_LAST) ? OFF_ZERO : offset_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Post-write buffer image so the window reflects same-cycle writes
    always_comb begin
        wr_ok_s = wr_en && (32'(wr_addr) < MSG_LEN);
        for (int i = 0; i < MSG_LEN; i++) begin
            msg_d[i] = (wr_ok_s && (32'(wr_addr) == 32'(i))) ? wr_data : msg_q[i];
        end
    end

    // Window gather: digit k shows buffer[(offset + k) mod MSG_LEN]
    always_comb begin
        window_d = 48'h2020_2020_2020;
        for (int k = 0; k < 6; k++) begin
            logic [31:0] idx;
            logic [7:0]  chr;
            idx = (32'(offset_d) + 32'(k)) % MSG_LEN;
            chr = 8'h20;
            for (int i = 0; i < MSG_LEN; i++) begin
                chr = (idx == 32'(i)) ? msg_d[i] : chr;
            end
            window_d[47 - 8*k -: 8] = chr;
        end
    end

    // Control and window registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= 32'd0;
            tick_q   <= 1'b0;
            offset_q <= OFF_ZERO;
            window_q <= 48'h2020_2020_2020;
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            offset_q <= offset_d;
            window_q <= window_d;
        end
    end

    // Message buffer storage, cleared to spaces on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= 8'h20;
            end
        end else begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= msg_d[i];
            end
        end
    end

    assign window = window_q;
    assign offset = offset_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_message_scroller.sv
// Self-checking bench for message_scroller against a behavioural model.
module tb_message_scroller;

    localparam int MSG_LEN  = 8;
    localparam int TICK_DIV = 4;
    localparam int ADDR_W   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              run, dir, step, clear, wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [47:0]       window;
    logic [ADDR_W-1:0] offset;
    logic              tick;

    int checks = 0;
    int errors = 0;

    logic [7:0] mbuf [MSG_LEN];
    int         moff;
    int         mphase;
    logic       mtick;

    always #5 clk = ~clk;

    message_scroller #(.MSG_LEN(MSG_LEN), .TICK_DIV(TICK_DIV), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .run(run), .dir(dir), .step(step), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .window(window), .offset(offset), .tick(tick)
    );

    task automatic model_reset();
        for (int i = 0; i < MSG_LEN; i++) mbuf[i] = 8'h20;
        moff   = 0;
        mphase = 0;
        mtick  = 1'b0;
    endtask

    function automatic logic [47:0] exp_window();
        logic [47:0] w;
        for (int k = 0; k < 6; k++) w[47 - 8*k -: 8] = mbuf[(moff + k) % MSG_LEN];
        return w;
    endfunction

    task automatic model_edge();
        logic adv, nt;
        if (!reset) begin
            model_reset();
        end else begin
            adv    = !clear && (run ? mtick : step);
            nt     = !clear && (mphase == TICK_DIV - 1);
            mphase = clear ? 0 : (mphase + 1) % TICK_DIV;
            if (clear) moff = 0;
            else if (adv) moff = dir ? (moff + MSG_LEN - 1) % MSG_LEN : (moff + 1) % MSG_LEN;
            if (wr_en && int'(wr_addr) < MSG_LEN) mbuf[wr_addr] = wr_data;
            mtick = nt;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; run = 1'b0; dir = 1'b0; step = 1'b0; clear = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = 8'h00;
        model_reset();
        cyc(); cyc();
        checks++; if (window !== 48'h202020202020) begin errors++; $display("FAIL reset_window: got %h expected %h", window, 48'h202020202020); end
        checks++; if (offset !== 4'd0) begin errors++; $display("FAIL reset_offset: got %0d expected 0", offset); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", tick); end
        reset = 1'b1;
    endtask

    task automatic test_load();
        string msg = "HELLO.CP";
        int nticks = 0;
        for (int i = 0; i < MSG_LEN; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = msg[i];
            cyc();
        end
        wr_en = 1'b0;
        checks++; if (window !== 48'h48454C4C4F2E) begin errors++; $display("FAIL load_window: got %h expected %h", window, 48'h48454C4C4F2E); end
        checks++; if (offset !== 4'd0) begin errors++; $display("FAIL load_offset: got %0d expected 0", offset); end
        for (int c = 0; c < 12; c++) begin
            cyc();
            if (tick === 1'b1) nticks++;
            checks++; if (tick !== mtick) begin errors++; $display("FAIL load_tick: got %b expected %b", tick, mtick); end
        end
        checks++; if (nticks != 3) begin errors++; $display("FAIL load_tick_count: got %0d expected 3", nticks); end
    endtask

    task automatic test_scroll_left();
        int seen7 = 0;
        int wraps = 0;
        run = 1'b1; dir = 1'b0;
        for (int c = 0; c < 40 && wraps == 0; c++) begin
            cyc();
            checks++; if (offset !== ADDR_W'(moff)) begin errors++; $display("FAIL left_offset: got %0d expected %0d", offset, moff); end
            checks++; if (window !== exp_window()) begin errors++; $display("FAIL left_window: got %h expected %h", window, exp_window()); end
            if (moff == 7 && seen7 == 0) begin
                seen7 = 1;
                checks++; if (window !== 48'h5048454C4C4F) begin errors++; $display("FAIL left_wrap_window: got %h expected %h", window, 48'h5048454C4C4F); end
            end
            if (moff == 0 && seen7 == 1) wraps = 1;
        end
        checks++; if (wraps != 1) begin errors++; $display("FAIL left_wrap_timeout: got %0d expected 1", wraps); end
        run = 1'b0;
    endtask

    task automatic test_scroll_right();
        int advs = 0;
        int prev;
        clear = 1'b1; cyc(); clear = 1'b0;
        checks++; if (offset !== 4'd0) begin errors++; $display("FAIL right_clear: got %0d expected 0", offset); end
        run = 1'b1; dir = 1'b1;
        for (int c = 0; c < 20 && advs < 2; c++) begin
            prev = moff;
            cyc();
            if (moff != prev) advs++;
            checks++; if (offset !== ADDR_W'(moff)) begin errors++; $display("FAIL right_offset: got %0d expected %0d", offset, moff); end
        end
        run = 1'b0;
        checks++; if (offset !== 4'd6) begin errors++; $display("FAIL right_final_offset: got %0d expected 6", offset); end
        checks++; if (window !== 48'h43504845_4C4C) begin errors++; $display("FAIL right_window: got %h expected %h", window, 48'h435048454C4C); end
    endtask

    task automatic test_step_priority();
        int prev;
        int n;
        for (int s = 0; s < 6; s++) begin
            dir = 1'($urandom % 2); step = 1'b1; cyc(); step = 1'b0;
            checks++; if (offset !== ADDR_W'(moff) || window !== exp_window()) begin errors++; $display("FAIL step: got %0d/%h expected %0d/%h", offset, window, moff, exp_window()); end
            cyc();
            checks++; if (offset !== ADDR_W'(moff)) begin errors++; $display("FAIL step_no_queue: got %0d expected %0d", offset, moff); end
        end
        for (int c = 0; c < 10 && mtick !== 1'b1; c++) cyc();
        prev = moff;
        run = 1'b1; step = 1'b1; dir = 1'b0; cyc(); run = 1'b0; step = 1'b0;
        checks++; if (offset !== ADDR_W'((prev + 1) % MSG_LEN)) begin errors++; $display("FAIL step_tick_single: got %0d expected %0d", offset, (prev + 1) % MSG_LEN); end
        for (int c = 0; c < 10 && mtick !== 1'b1; c++) cyc();
        clear = 1'b1; cyc(); clear = 1'b0;
        checks++; if (offset !== 4'd0) begin errors++; $display("FAIL clear_offset: got %0d expected 0", offset); end
        n = 0;
        for (int c = 0; c < 10 && tick !== 1'b1; c++) begin cyc(); n++; end
        checks++; if (n != TICK_DIV) begin errors++; $display("FAIL clear_restart: got %0d expected %0d", n, TICK_DIV); end
    endtask

    task automatic test_writes();
        logic [47:0] saved;
        wr_en = 1'b1; wr_addr = ADDR_W'((moff + 5) % MSG_LEN); wr_data = 8'h49; cyc(); wr_en = 1'b0;
        checks++; if (window[7:0] !== 8'h49) begin errors++; $display("FAIL write_hex0: got %h expected 49", window[7:0]); end
        saved = window;
        wr_en = 1'b1; wr_addr = 4'd8; wr_data = 8'($urandom); cyc(); wr_en = 1'b0;
        checks++; if (window !== saved || window !== exp_window()) begin errors++; $display("FAIL write_oob: got %h expected %h", window, saved); end
        for (int c = 0; c < 40; c++) begin
            wr_en = 1'($urandom % 2); wr_addr = ADDR_W'($urandom % 16); wr_data = 8'($urandom);
            run = 1'($urandom % 2); dir = 1'($urandom % 2); step = 1'($urandom % 2);
            clear = ($urandom % 10) == 0;
            cyc();
            checks++; if (window !== exp_window()) begin errors++; $display("FAIL rand_window: got %h expected %h", window, exp_window()); end
            checks++; if (offset !== ADDR_W'(moff) || tick !== mtick) begin errors++; $display("FAIL rand_offset_tick: got %0d/%b expected %0d/%b", offset, tick, moff, mtick); end
        end
        wr_en = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0;
    endtask

    task automatic test_async_reset();
        run = 1'b1; dir = 1'b0;
        for (int c = 0; c < 9; c++) cyc();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        checks++; if (window !== 48'h202020202020) begin errors++; $display("FAIL async_window: got %h expected %h", window, 48'h202020202020); end
        checks++; if (offset !== 4'd0) begin errors++; $display("FAIL async_offset: got %0d expected 0", offset); end
        checks++; if (tick !== 1'b0) begin errors++; $display("FAIL async_tick: got %b expected 0", tick); end
        run = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        for (int s = 0; s < MSG_LEN; s++) begin
            step = 1'b1; dir = 1'b0; cyc(); step = 1'b0;
            checks++; if (window !== 48'h202020202020) begin errors++; $display("FAIL async_buffer: got %h expected %h", window, 48'h202020202020); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_scroll_left();
        test_scroll_right();
        test_step_priority();
        test_writes();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
